adder_result_stage: RTL and testbench
=====================================

// Module: adder_result_stage
// PURPOSE
//  Downstream stage of the 4-bit adder/subtractor: captures its combinational {Cout,Res}
//  plus operand sign info, derives Z/N/C/V status flags, and queues result+flags in a
//  small FIFO behind a valid/ready handshake toward the register-file/flags writeback.
//  Decouples the combinational ALU from a stalling consumer; keeps a sticky overflow flag.
// PARAMETERS
//  WIDTH  4  data width of Res/out_res (matches the adder/subtractor)
//  DEPTH  2  FIFO entries; power of two, >= 2
// PORTS
//  clk              in   1            rising-edge clock
//  rst              in   1            synchronous reset, active-high
//  in_valid         in   1            adder output presented this cycle
//  in_ready         out  1            stage can accept an entry
//  Res              in   WIDTH        adder result
//  Cout             in   1            adder carry-out (1 = no borrow when subtracting)
//  A_msb            in   1            MSB of operand A
//  B_msb            in   1            MSB of operand B (before subtract inversion)
//  subtract_enable  in   1            operation was A-B
//  out_valid        out  1            head entry available
//  out_ready        in   1            consumer accepts head entry
//  out_res          out  WIDTH        head result
//  out_c,out_z,out_n,out_v out 1 each head carry/zero/negative/overflow flags
//  count            out  clog2(DEPTH)+1 entries held
//  v_sticky         out  1            set by any accepted entry with V=1
//  v_sticky_clr     in   1            clears v_sticky
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0, in_ready=0 during rst cycle then 1, out_valid=0,
//    out_res=0, all out flags=0, v_sticky=0. Reset mid-transfer discards all entries.
//  - Flags computed at push from inputs: Z=(Res==0); N=Res[WIDTH-1]; C=Cout (raw);
//    V=(A_msb==(B_msb^subtract_enable)) && (Res[WIDTH-1]!=A_msb). Stored per entry.
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//  - in_ready = !rst && (count<DEPTH); from registered count only, no out_ready path.
//  - out_valid = (count!=0). out_* show head entry; forced to 0 when count==0.
//  - Latency: push into empty FIFO -> out_valid=1 next cycle; no same-cycle bypass.
//  - States (from count): EMPTY(0) -> PARTIAL on push; PARTIAL -> FULL on push w/o pop,
//    -> EMPTY on pop w/o push (count 1); push+pop holds count; FULL -> PARTIAL on pop.
//  - FULL: in_ready=0 even if out_ready=1 that cycle; entry accepted cycle after pop.
//  - EMPTY: out_ready ignored, count never underflows; simultaneous push+pop impossible.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; FIFO order strictly preserved.
//  - v_sticky: set on push with V=1; cleared by v_sticky_clr; set wins if same cycle.
//  - in_valid while in_ready=0: inputs ignored, no state change (producer must hold).
// TESTING
//  1 rst 2 cycles -> count=0,out_valid=0,out_*=0,v_sticky=0; in_ready=1 cycle after rst drops.
//  2 push Res=4'h0,Cout=1,sub=1,A_msb=0,B_msb=0 -> next cycle out_valid=1,out_z=1,out_c=1,out_v=0.
//  3 push A=7+B=1: Res=4'h8,Cout=0,A_msb=0,B_msb=0,sub=0 -> out_n=1,out_v=1,v_sticky=1.
//  4 out_ready=0, push 3 entries 1,2,3 -> third stalls (in_ready=0,count=2); drain -> 1,2 then 3.
//  5 count=1, push+pop same cycle -> count stays 1; 8 entries streamed, no loss across wrap.
//  6 v_sticky_clr with V=1 push same cycle -> v_sticky=1; clr alone -> 0; rst mid-fill -> count=0.

Source files
------------

// File: rtl/adder_result_stage.sv
// Result stage behind the 4-bit adder/subtractor: derives Z/N/C/V per result and queues
// result+flags in a small FIFO toward writeback, with a sticky overflow indicator.
module adder_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         Res,
  input  logic                     Cout,
  input  logic                     A_msb,
  input  logic                     B_msb,
  input  logic                     subtract_enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_res,
  output logic                     out_c,
  output logic                     out_z,
  output logic                     out_n,
  output logic                     out_v,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     v_sticky,
  input  logic                     v_sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // Flags packed as {c, z, n, v}; the effective B sign is inverted when subtracting.
  function automatic logic [3:0] calc_flags(
    input logic [WIDTH-1:0] res,
    input logic             cout,
    input logic             a_msb,
    input logic             b_msb,
    input logic             sub
  );
    logic z_f;
    logic v_f;
    z_f = (res == {WIDTH{1'b0}});
    v_f = (a_msb == (b_msb ^ sub)) && (res[WIDTH-1] != a_msb);
    return {cout, z_f, res[WIDTH-1], v_f};
  endfunction

  logic [WIDTH-1:0] res_mem_r   [DEPTH];
  logic [3:0]       flag_mem_r  [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             v_sticky_r;
  logic [3:0]       in_flags_s;
  logic             push_s;
  logic             pop_s;
  logic             not_empty_s;

  assign in_flags_s  = calc_flags(Res, Cout, A_msb, B_msb, subtract_enable);
  assign not_empty_s = (count_r != CNT_ZERO);
  assign in_ready    = !rst && (count_r < CNT_DEPTH);
  assign out_valid   = not_empty_s;
  assign push_s      = in_valid && in_ready;
  assign pop_s       = not_empty_s && out_ready;
  assign count       = count_r;
  assign v_sticky    = v_sticky_r;

  // Entry storage and write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_r[i]  <= {WIDTH{1'b0}};
        flag_mem_r[i] <= 4'b0000;
      end
    end else if (push_s) begin
      res_mem_r[wr_ptr_r]  <= Res;
      flag_mem_r[wr_ptr_r] <= in_flags_s;
      wr_ptr_r             <= wr_ptr_r + PTR_ONE;
    end
  end

  // Read pointer and occupancy; push+pop in the same cycle leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_sticky_r <= 1'b0;
    end else if (push_s && in_flags_s[0]) begin
      v_sticky_r <= 1'b1;
    end else if (v_sticky_clr) begin
      v_sticky_r <= 1'b0;
    end
  end

  // Head presentation, zeroed while empty.
  always_comb begin
    out_res = {WIDTH{1'b0}};
    out_c   = 1'b0;
    out_z   = 1'b0;
    out_n   = 1'b0;
    out_v   = 1'b0;
    if (not_empty_s) begin
      out_res = res_mem_r[rd_ptr_r];
      {out_c, out_z, out_n, out_v} = flag_mem_r[rd_ptr_r];
    end else begin
      out_res = {WIDTH{1'b0}};
      {out_c, out_z, out_n, out_v} = 4'b0000;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage: flag derivation, FIFO ordering, stall,
// stream-through across pointer wrap, sticky overflow and mid-fill reset.
module tb_adder_result_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Res;
  logic       Cout;
  logic       A_msb;
  logic       B_msb;
  logic       subtract_enable;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_res;
  logic       out_c;
  logic       out_z;
  logic       out_n;
  logic       out_v;
  logic [1:0] count;
  logic       v_sticky;
  logic       v_sticky_clr;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_head;

  adder_result_stage #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Res(Res), .Cout(Cout), .A_msb(A_msb), .B_msb(B_msb),
    .subtract_enable(subtract_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v),
    .count(count), .v_sticky(v_sticky), .v_sticky_clr(v_sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic c, input logic a, input logic b,
                       input logic s);
    in_valid        = 1'b1;
    Res             = r;
    Cout            = c;
    A_msb           = a;
    B_msb           = b;
    subtract_enable = s;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; Res = 4'h0; Cout = 1'b0; A_msb = 1'b0; B_msb = 1'b0;
    subtract_enable = 1'b0; out_ready = 1'b0; v_sticky_clr = 1'b0;
    step();
    step();
    // Reset state
    check_val("rst_in_ready",  32'(in_ready), 32'd0);
    check_val("rst_count",     32'(count), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_res",   32'(out_res), 32'd0);
    check_val("rst_flags",     32'({out_c, out_z, out_n, out_v}), 32'd0);
    check_val("rst_v_sticky",  32'(v_sticky), 32'd0);
    rst = 1'b0;
    step();
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Empty FIFO ignores out_ready
    out_ready = 1'b1;
    step();
    check_val("empty_pop_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Zero result of subtraction: Z=1, C=1, V=0, no same-cycle bypass
    drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("no_bypass_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check_val("t2_out_valid", 32'(out_valid), 32'd1);
    check_val("t2_flags_czvn", 32'({out_c, out_z, out_n, out_v}), 32'b1100);
    check_val("t2_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("t2_drain_count", 32'(count), 32'd0);
    check_val("t2_drain_res", 32'(out_res), 32'd0);

    // 7+1 overflows: N=1, V=1, sticky set
    drive(4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check_val("t3_res", 32'(out_res), 32'h8);
    check_val("t3_flags_czvn", 32'({out_c, out_z, out_n, out_v}), 32'b0011);
    check_val("t3_v_sticky", 32'(v_sticky), 32'd1);
    out_ready = 1'b1;
    v_sticky_clr = 1'b1;
    step();
    out_ready = 1'b0;
    v_sticky_clr = 1'b0;
    check_val("t3_sticky_clr", 32'(v_sticky), 32'd0);
    check_val("t3_count", 32'(count), 32'd0);

    // Fill to FULL, stall the third, then drain in order
    drive(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("t4_full_count", 32'(count), 32'd2);
    check_val("t4_full_ready", 32'(in_ready), 32'd0);
    drive(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_val("t4_stall_count", 32'(count), 32'd2);
    check_val("t4_head1", 32'(out_res), 32'h1);
    out_ready = 1'b1;
    check_val("t4_full_ready_pop", 32'(in_ready), 32'd0);
    step();
    check_val("t4_after_pop_count", 32'(count), 32'd1);
    check_val("t4_head2", 32'(out_res), 32'h2);
    check_val("t4_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_val("t4_pushpop_count", 32'(count), 32'd1);
    check_val("t4_head3", 32'(out_res), 32'h3);
    step();
    out_ready = 1'b0;
    check_val("t4_drained", 32'(count), 32'd0);

    // Stream 8 entries through with count held at 1 (pointer wrap)
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_head = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      drive(4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      check_val("t5_head", 32'(out_res), 32'(exp_head));
      step();
      exp_head = 4'(i);
      check_val("t5_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    check_val("t5_last_head", 32'(out_res), 32'h8);
    step();
    out_ready = 1'b0;
    check_val("t5_drained", 32'(count), 32'd0);
    v_sticky_clr = 1'b1;
    step();
    v_sticky_clr = 1'b0;
    check_val("t6_pre_clear", 32'(v_sticky), 32'd0);

    // Overflow push beats a same-cycle clear; clear alone then works
    drive(4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    v_sticky_clr = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("t6_set_wins", 32'(v_sticky), 32'd1);
    step();
    v_sticky_clr = 1'b0;
    check_val("t6_clr_alone", 32'(v_sticky), 32'd0);

    // Reset mid-fill discards entries
    drive(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check_val("t6_fill_count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    check_val("t6_rst_count", 32'(count), 32'd0);
    check_val("t6_rst_valid", 32'(out_valid), 32'd0);
    check_val("t6_rst_res", 32'(out_res), 32'd0);
    rst = 1'b0;
    step();
    check_val("t6_rst_ready", 32'(in_ready), 32'd1);
    check_val("t6_rst_count2", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
